// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers for the E stage.
// Results are computed at issue, held in pending registers, and committed after the latency.
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             o_dbg_state
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};

  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic             r_done;

  logic signed [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0]        w_prod_u;
  logic signed [WIDTH-1:0]   w_q_s, w_r_s;
  logic [WIDTH-1:0]          w_pend_hi, w_pend_lo;

  assign w_prod_s = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
  assign w_prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  // Signed divide truncates toward zero; remainder follows the dividend's sign.
  assign w_q_s = $signed(A) / $signed(B);
  assign w_r_s = $signed(A) % $signed(B);

  always_comb begin
    w_pend_hi = '0;
    w_pend_lo = '0;
    case (op)
      3'd0: {w_pend_hi, w_pend_lo} = w_prod_s;
      3'd1: {w_pend_hi, w_pend_lo} = w_prod_u;
      3'd2: begin
        if (B == '0) begin
          w_pend_hi = A;
          w_pend_lo = '1;
        end else if (A == MIN_S && B == '1) begin
          w_pend_hi = '0;
          w_pend_lo = A;
        end else begin
          w_pend_hi = w_r_s;
          w_pend_lo = w_q_s;
        end
      end
      3'd3: begin
        if (B == '0) begin
          w_pend_hi = A;
          w_pend_lo = '1;
        end else begin
          w_pend_hi = A % B;
          w_pend_lo = A / B;
        end
      end
      default: ;
    endcase
  end

  // A start arriving while RUN is dropped; the hazard logic never issues one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (op <= 3'd3) begin
              r_pend_hi <= w_pend_hi;
              r_pend_lo <= w_pend_lo;
              r_cnt     <= op[1] ? DIV_N : MULT_N;
              r_state   <= ST_RUN;
            end else if (op == 3'd4) begin
              r_hi <= A;
            end else if (op == 3'd5) begin
              r_lo <= A;
            end
          end
        end
        default: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_hi    <= r_pend_hi;
            r_lo    <= r_pend_lo;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy        = (r_state == ST_RUN);
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign o_dbg_state = r_state[0];

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, busy/done timing,
// MTHI/MTLO, ignored starts and reset abort.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, dbg_state;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a mult/div, scramble A/B, check busy for n cycles, then the result and done pulse.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] va,
                        input logic [W-1:0] vb, input int n,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    op = o; a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom_range(0, 32'hFFFF);
    b = $urandom_range(1, 32'hFFFF);
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_nodone"}, 64'(done), 64'd0);
      tick();
    end
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    tick();
    check({tag, "_done_clr"}, 64'(done), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    tick();
    reset = 1'b0;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);

    run_op("mult_neg",  3'd0, 32'hFFFFFFFD, 32'd7,        5, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'd2,        5, 32'h00000001, 32'hFFFFFFFE);
    run_op("div_neg",   3'd2, 32'hFFFFFFF9, 32'd2,       10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negb",  3'd2, 32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
    run_op("div_ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
    run_op("div_zero",  3'd2, 32'hFFFFFFFB, 32'd0,       10, 32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("divu_zero", 3'd3, 32'd9,        32'd0,       10, 32'h00000009, 32'hFFFFFFFF);
    run_op("divu",      3'd3, 32'd100,      32'd7,       10, 32'h00000002, 32'h0000000E);

    // MTHI / MTLO take effect at the issue edge with no busy or done.
    op = 3'd4; a = 32'h1234; start = 1'b1;
    tick();
    start = 1'b0;
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd0);
    op = 3'd5; a = 32'h5678; start = 1'b1;
    tick();
    start = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h5678);
    check("mtlo_hi", 64'(hi), 64'h1234);
    check("mtlo_busy", 64'(busy), 64'd0);

    // Opcodes 6 and 7 leave everything untouched.
    op = 3'd6; a = 32'hAAAA; start = 1'b1;
    tick();
    op = 3'd7;
    tick();
    start = 1'b0;
    check("nop_hi", 64'(hi), 64'h1234);
    check("nop_lo", 64'(lo), 64'h5678);
    check("nop_busy", 64'(busy), 64'd0);

    // MULT 3*4, with an MTLO and a MULT start thrown in during RUN.
    op = 3'd0; a = 32'd3; b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    op = 3'd5; a = 32'hDEAD; start = 1'b1;
    tick();
    op = 3'd0; a = 32'd100; b = 32'd100;
    tick();
    start = 1'b0;
    check("ign_lo_mid", 64'(lo), 64'h5678);
    check("ign_busy_mid", 64'(busy), 64'd1);
    tick();
    check("ign_busy_last", 64'(busy), 64'd1);
    tick();
    check("ign_done", 64'(done), 64'd1);
    check("ign_busy_end", 64'(busy), 64'd0);
    check("ign_hi", 64'(hi), 64'd0);
    check("ign_lo", 64'(lo), 64'd12);

    // Reset four cycles into a DIV: result discarded, no done pulse later.
    op = 3'd2; a = 32'd100; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    for (int i = 0; i < 12; i++) begin
      check("abort_nodone", 64'(done), 64'd0);
      tick();
    end
    check("abort_lo_end", 64'(lo), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
